// File: rtl/upg_word_loader.sv
// upg_word_loader: parses a length-prefixed UART byte frame into 32-bit little-endian
// ROM words and drives the UPG write port with sequential addresses.
module upg_word_loader #(
    parameter int ADDR_W      = 14,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              upg_clk_i,
    input  logic              upg_rstn_i,
    input  logic [7:0]        rx_dat_i,
    input  logic              rx_vld_i,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              upg_err_o
);
    typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR} state_t;

    localparam int          TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

    state_t          state, state_nx;
    logic [15:0]     len;
    logic [15:0]     len_nx;
    logic [23:0]     part;
    logic [1:0]      byte_cnt;
    logic [ADDR_W:0] word_idx;
    logic [TW-1:0]   tmo;
    logic            expired;
    logic            last_wr;
    logic            counting;

    assign len_nx     = {rx_dat_i, len[7:0]};
    assign counting   = (state == S_LEN1) || (state == S_DATA);
    assign expired    = !rx_vld_i && (tmo == TW'(TIMEOUT_CYC - 1));
    // word_idx has already advanced past the word being strobed
    assign last_wr    = upg_wen_o && (17'(word_idx) == {1'b0, len});
    assign upg_done_o = (state == S_DONE);
    assign upg_err_o  = (state == S_ERR);

    always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
        if (!upg_rstn_i) state <= S_LEN0;
        else             state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_LEN0:  state_nx = rx_vld_i ? S_LEN1 : S_LEN0;
            S_LEN1:  state_nx = rx_vld_i ? (len_nx == 16'd0 ? S_DONE :
                                            {1'b0, len_nx} > MAX_N ? S_ERR : S_DATA)
                                         : (expired ? S_ERR : S_LEN1);
            S_DATA:  state_nx = last_wr ? S_DONE : (expired ? S_ERR : S_DATA);
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
        if (!upg_rstn_i) begin
            len       <= '0;
            part      <= '0;
            byte_cnt  <= '0;
            word_idx  <= '0;
            tmo       <= '0;
            upg_wen_o <= 1'b0;
            upg_adr_o <= '0;
            upg_dat_o <= '0;
        end else begin
            upg_wen_o <= 1'b0;
            tmo       <= (rx_vld_i || !counting) ? '0 : tmo + 1'b1;
            if (rx_vld_i && state == S_LEN0) len[7:0]  <= rx_dat_i;
            if (rx_vld_i && state == S_LEN1) len[15:8] <= rx_dat_i;
            if (rx_vld_i && state == S_DATA) begin
                byte_cnt <= byte_cnt + 1'b1;
                if (byte_cnt == 2'd3) begin
                    upg_wen_o <= 1'b1;
                    upg_adr_o <= word_idx[ADDR_W-1:0];
                    upg_dat_o <= {rx_dat_i, part};
                    word_idx  <= word_idx + 1'b1;
                end else begin
                    part[byte_cnt*8 +: 8] <= rx_dat_i;
                end
            end
        end
    end
endmodule
